// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        SIZE_BYTE = 1'b0,
        SIZE_WORD = 1'b1
    } size_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } requester_e;

    localparam int unsigned WORD_BEATS = 4;

    // Index of the final beat of an access of the given size.
    function automatic logic [1:0] last_beat(input size_e size);
        return (size == SIZE_WORD) ? 2'(WORD_BEATS - 1) : 2'd0;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes and byte-wide memory bus of the arbiter.
interface mem_arbiter_if;

    logic        fetch_req_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_done_o;
    logic [31:0] fetch_rdata_o;

    logic        data_req_i;
    logic        data_we_i;
    logic        data_size_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_done_o;
    logic [31:0] data_rdata_o;

    logic [31:0] mem_address_o;
    logic        mem_write_enable_o;
    logic [7:0]  mem_write_data_o;
    logic [7:0]  mem_data_i;

    logic        busy_o;

    // Arbiter side.
    modport slave (
        input  fetch_req_i, fetch_addr_i,
        output fetch_done_o, fetch_rdata_o,
        input  data_req_i, data_we_i, data_size_i, data_addr_i, data_wdata_i,
        output data_done_o, data_rdata_o,
        output mem_address_o, mem_write_enable_o, mem_write_data_o,
        input  mem_data_i,
        output busy_o
    );

    // Requester and memory side.
    modport master (
        output fetch_req_i, fetch_addr_i,
        input  fetch_done_o, fetch_rdata_o,
        output data_req_i, data_we_i, data_size_i, data_addr_i, data_wdata_i,
        input  data_done_o, data_rdata_o,
        input  mem_address_o, mem_write_enable_o, mem_write_data_o,
        output mem_data_i,
        input  busy_o
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin selector: bit 0 = fetch, bit 1 = data.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  requester_e last_grant,
    output logic [1:0] grant
);

    // Lone request wins outright; on contention the one not served last wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == GNT_DATA) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto a byte-wide memory with a
// registered read port, serialising words into four little-endian beats.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input logic          clk,
    input logic          reset_ni,
    mem_arbiter_if.slave bus
);

    state_e      state_q, state_d;
    requester_e  owner_q, last_grant_q;
    logic        we_q;
    size_e       size_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  beat_q;
    logic [31:0] asm_q, asm_d;
    logic [31:0] fetch_rdata_q, data_rdata_q;

    logic [1:0]  grant;
    logic        accept;
    logic        capture;
    logic [1:0]  cap_idx;
    logic [31:0] mem_address;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        fetch_done, data_done;

    rr_arb2 u_rr_arb2 (
        .req        ({bus.data_req_i, bus.fetch_req_i}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next state plus memory-bus and completion outputs.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        mem_address = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        fetch_done  = 1'b0;
        data_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    accept  = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                mem_address = (size_q == SIZE_WORD) ? {addr_q[31:2], beat_q} : addr_q;
                mem_we      = we_q;
                if (we_q) mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
                if (beat_q == last_beat(size_q)) state_d = we_q ? DONE : DRAIN;
            end
            DRAIN: state_d = DONE;
            DONE: begin
                fetch_done = (owner_q == GNT_FETCH);
                data_done  = (owner_q == GNT_DATA);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data lags its address by one cycle, so each capture lands in the
    // byte lane of the previous beat; DRAIN picks up the final beat.
    always_comb begin
        cap_idx = beat_q - 2'd1;
        capture = !we_q && ((state_q == XFER && beat_q != 2'd0) || state_q == DRAIN);
        asm_d   = asm_q;
        if (capture) asm_d[{cap_idx, 3'b000} +: 8] = bus.mem_data_i;
    end

    // Request latching, beat counting, load assembly and result registers.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            owner_q       <= GNT_FETCH;
            last_grant_q  <= GNT_FETCH;
            we_q          <= 1'b0;
            size_q        <= SIZE_BYTE;
            addr_q        <= '0;
            wdata_q       <= '0;
            beat_q        <= '0;
            asm_q         <= '0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            asm_q <= asm_d;
            if (accept) begin
                beat_q <= '0;
                asm_q  <= '0;
                if (grant[0]) begin
                    owner_q      <= GNT_FETCH;
                    last_grant_q <= GNT_FETCH;
                    we_q         <= 1'b0;
                    size_q       <= SIZE_WORD;
                    addr_q       <= bus.fetch_addr_i;
                    wdata_q      <= '0;
                end else begin
                    owner_q      <= GNT_DATA;
                    last_grant_q <= GNT_DATA;
                    we_q         <= bus.data_we_i;
                    size_q       <= size_e'(bus.data_size_i);
                    addr_q       <= bus.data_addr_i;
                    wdata_q      <= bus.data_wdata_i;
                end
            end
            if (state_q == XFER) beat_q <= beat_q + 2'd1;
            if (state_q == DRAIN) begin
                if (owner_q == GNT_FETCH) fetch_rdata_q <= asm_d;
                else                      data_rdata_q  <= asm_d;
            end
        end
    end

    assign bus.fetch_done_o       = fetch_done;
    assign bus.fetch_rdata_o      = fetch_rdata_q;
    assign bus.data_done_o        = data_done;
    assign bus.data_rdata_o       = data_rdata_q;
    assign bus.mem_address_o      = mem_address;
    assign bus.mem_write_enable_o = mem_we;
    assign bus.mem_write_data_o   = mem_wdata;
    assign bus.busy_o             = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions and
// memory writes, monitors pop and compare on the falling edge.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        bit          is_fetch;
        logic [31:0] rdata;
        int unsigned cycle;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    done_t done_q[$];
    wr_t   wr_q[$];
    done_t md;
    wr_t   mw;

    logic [7:0] mem [0:4095];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk      (clk),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Byte memory with registered read port.
    always @(posedge clk) begin
        if (bus.mem_write_enable_o) mem[bus.mem_address_o[11:0]] <= bus.mem_write_data_o;
        bus.mem_data_i <= mem[bus.mem_address_o[11:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_done(input bit is_fetch, input logic [31:0] rdata, input int unsigned cycle);
        done_t d;
        d.is_fetch = is_fetch;
        d.rdata    = rdata;
        d.cycle    = cycle;
        done_q.push_back(d);
    endtask

    task automatic exp_wr(input logic [31:0] addr, input logic [7:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        wr_q.push_back(w);
    endtask

    // Write and completion monitor.
    always @(negedge clk) begin
        if (bus.mem_write_enable_o) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", bus.mem_address_o, 32'hFFFF_FFFF);
            end else begin
                mw = wr_q.pop_front();
                check("wr_addr", bus.mem_address_o, mw.addr);
                check("wr_data", 32'(bus.mem_write_data_o), 32'(mw.data));
            end
        end
        if (bus.fetch_done_o || bus.data_done_o) begin
            check("single_done", 32'(bus.fetch_done_o & bus.data_done_o), 32'd0);
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'(bus.fetch_done_o), 32'hFFFF_FFFF);
            end else begin
                md = done_q.pop_front();
                check("done_who", 32'(bus.fetch_done_o), 32'(md.is_fetch));
                check("done_cycle", cyc, md.cycle);
                check(md.is_fetch ? "fetch_rdata" : "data_rdata",
                      md.is_fetch ? bus.fetch_rdata_o : bus.data_rdata_o, md.rdata);
            end
        end
    end

    task automatic wait_idle();
        int unsigned n = 0;
        while (bus.busy_o && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", 32'(bus.busy_o), 32'd0);
    endtask

    // One request with given latency; expected completion is queued here.
    task automatic do_req(input bit is_fetch, input bit we, input bit word,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int unsigned lat, input logic [31:0] exp_rdata);
        int unsigned g;
        @(posedge clk);
        #1;
        if (is_fetch) begin
            bus.fetch_req_i  = 1'b1;
            bus.fetch_addr_i = addr;
        end else begin
            bus.data_req_i   = 1'b1;
            bus.data_we_i    = we;
            bus.data_size_i  = word;
            bus.data_addr_i  = addr;
            bus.data_wdata_i = wdata;
        end
        g = cyc;
        exp_done(is_fetch, exp_rdata, g + lat);
        @(posedge clk);
        #1;
        bus.fetch_req_i = 1'b0;
        bus.data_req_i  = 1'b0;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned g0;
        int unsigned n;
        int unsigned t;

        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
        mem[12'h104] = 8'h78; mem[12'h105] = 8'h56; mem[12'h106] = 8'h34; mem[12'h107] = 8'h12;
        mem[12'h1FC] = 8'h01; mem[12'h1FD] = 8'h02; mem[12'h1FE] = 8'h03; mem[12'h1FF] = 8'h04;
        mem[12'h011] = 8'h9C;
        mem[12'h300] = 8'h00; mem[12'h301] = 8'h00; mem[12'h302] = 8'h00; mem[12'h303] = 8'h00;

        // Both requesters asserted from reset onward.
        bus.fetch_req_i  = 1'b1;
        bus.fetch_addr_i = 32'h0000_0104;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b0;
        bus.data_size_i  = 1'b0;
        bus.data_addr_i  = 32'h0000_0011;
        bus.data_wdata_i = 32'h0;
        bus.mem_data_i   = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_fetch_done", 32'(bus.fetch_done_o), 32'd0);
        check("rst_data_done", 32'(bus.data_done_o), 32'd0);
        check("rst_fetch_rdata", bus.fetch_rdata_o, 32'd0);
        check("rst_data_rdata", bus.data_rdata_o, 32'd0);
        check("rst_mem_addr", bus.mem_address_o, 32'd0);
        check("rst_mem_we", 32'(bus.mem_write_enable_o), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_write_data_o), 32'd0);

        // Contention: data first, then alternating, back-to-back.
        reset_ni = 1'b1;
        g0 = cyc;
        exp_done(1'b0, 32'h0000_009C, g0 + 3);
        exp_done(1'b1, 32'h1234_5678, g0 + 10);
        exp_done(1'b0, 32'h0000_009C, g0 + 14);
        exp_done(1'b1, 32'h1234_5678, g0 + 21);
        n = 0;
        t = 0;
        while (n < 4 && t < 60) begin
            @(negedge clk);
            t++;
            if (bus.fetch_done_o || bus.data_done_o) n++;
        end
        check("contention_dones", n, 32'd4);
        bus.fetch_req_i = 1'b0;
        bus.data_req_i  = 1'b0;
        wait_idle();

        // Directed single transactions.
        do_req(1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 6, 32'h1234_5678);
        do_req(1'b1, 1'b0, 1'b1, 32'h0000_01FE, 32'h0, 6, 32'h0403_0201);

        exp_wr(32'h0000_0200, 8'hEF);
        exp_wr(32'h0000_0201, 8'hBE);
        exp_wr(32'h0000_0202, 8'hAD);
        exp_wr(32'h0000_0203, 8'hDE);
        do_req(1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'hDEAD_BEEF, 5, 32'h0000_009C);

        exp_wr(32'h0000_0040, 8'hA5);
        do_req(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_FFA5, 2, 32'h0000_009C);

        do_req(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 3, 32'h0000_00A5);
        do_req(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 6, 32'hDEAD_BEEF);
        check("fetch_rdata_hold", bus.fetch_rdata_o, 32'h0403_0201);
        check("mem_0x41_untouched", 32'(mem[12'h041]), 32'(8'(12'h041 * 7 + 3)));

        // Reset during beat 2 of a word store.
        exp_wr(32'h0000_0300, 8'h88);
        exp_wr(32'h0000_0301, 8'h77);
        @(posedge clk);
        #1;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b1;
        bus.data_size_i  = 1'b1;
        bus.data_addr_i  = 32'h0000_0300;
        bus.data_wdata_i = 32'h5566_7788;
        @(posedge clk);
        #1;
        bus.data_req_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_ni = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        check("abort_mem_we", 32'(bus.mem_write_enable_o), 32'd0);
        check("abort_mem_addr", bus.mem_address_o, 32'd0);
        check("abort_data_rdata", bus.data_rdata_o, 32'd0);
        check("abort_fetch_rdata", bus.fetch_rdata_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_ni = 1'b1;
        check("abort_byte0", 32'(mem[12'h300]), 32'h88);
        check("abort_byte1", 32'(mem[12'h301]), 32'h77);
        check("abort_byte2", 32'(mem[12'h302]), 32'h00);
        check("abort_byte3", 32'(mem[12'h303]), 32'h00);

        do_req(1'b0, 1'b0, 1'b0, 32'h0000_0011, 32'h0, 3, 32'h0000_009C);

        repeat (3) @(posedge clk);
        #1;
        check("pending_dones", done_q.size(), 32'd0);
        check("pending_writes", wr_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
